// File: rtl/conv_pkg.sv
// Shared types for the 3x3 window generator feeding the two-channel conv kernel.
package conv_pkg;

   localparam int KSIZE = 3;

   typedef logic [15:0] fp16_t;
   typedef fp16_t [8:0] win3x3_t;
   typedef fp16_t [KSIZE-1:0] col3_t;   // one window column: [0]=row-2, [1]=row-1, [2]=row

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } win_state_e;

   // Assemble a window from three columns, oldest column first; index = 3*r + c.
   function automatic win3x3_t pack_win(input col3_t c0, input col3_t c1, input col3_t c2);
      win3x3_t w;
      for (int r = 0; r < KSIZE; r++) begin
         w[KSIZE*r + 0] = c0[r];
         w[KSIZE*r + 1] = c1[r];
         w[KSIZE*r + 2] = c2[r];
      end
      return w;
   endfunction

endpackage

// File: rtl/conv_line_buf.sv
// Two-row pixel delay line for one channel. A write at column addr returns the
// pixels seen at the same column one and two rows earlier (read before write).
// Contents are deliberately not reset; the caller masks stale entries.
module conv_line_buf
   import conv_pkg::*;
#(
   parameter int DEPTH = 28
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH)-1:0]   addr,
   input  logic [15:0]                din,
   output logic [15:0]                row_1,
   output logic [15:0]                row_2
);

   fp16_t mem_1 [DEPTH];
   fp16_t mem_2 [DEPTH];

   assign row_1 = mem_1[addr];
   assign row_2 = mem_2[addr];

   // Shift the column down one row: newest pixel into mem_1, previous occupant into mem_2.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_1[addr] <= din;
         mem_2[addr] <= mem_1[addr];
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator, two FP16 channels, valid-mode (no padding).
//
// state | meaning
// IDLE  | waiting for start, pixel beats ignored
// RUN   | accepting raster-order pixels, emitting windows
// DONE  | one-cycle done pulse after the last pixel of the frame
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [15:0]       in_px_1,
   input  logic [15:0]       in_px_2,
   output logic              win_valid,
   output logic [8:0][15:0]  ifmap_1,
   output logic [8:0][15:0]  ifmap_2,
   output logic              win_last,
   output logic              busy,
   output logic              done
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   win_state_e    state_q, state_d;
   logic [CW-1:0] col_q;
   logic [RW-1:0] row_q;
   logic          accept;
   logic          last_px;
   logic          win_ok;

   fp16_t         lb_1_r1, lb_1_r2, lb_2_r1, lb_2_r2;
   col3_t         sh_1_a, sh_1_b, sh_2_a, sh_2_b;   // a = column col-2, b = column col-1
   col3_t         new_1, new_2;

   // A beat coinciding with start belongs to neither the old nor the new frame.
   assign accept  = (state_q == RUN) && in_valid && !start;
   assign last_px = (col_q == COL_LAST) && (row_q == ROW_LAST);
   assign win_ok  = (col_q >= CW'(2)) && (row_q >= RW'(2));

   assign new_1 = {in_px_1, lb_1_r1, lb_1_r2};
   assign new_2 = {in_px_2, lb_2_r1, lb_2_r2};

   conv_line_buf #(.DEPTH(IMG_W)) u_lb_1 (
      .clk   (clk),
      .wr_en (accept),
      .addr  (col_q),
      .din   (in_px_1),
      .row_1 (lb_1_r1),
      .row_2 (lb_1_r2)
   );

   conv_line_buf #(.DEPTH(IMG_W)) u_lb_2 (
      .clk   (clk),
      .wr_en (accept),
      .addr  (col_q),
      .din   (in_px_2),
      .row_1 (lb_2_r1),
      .row_2 (lb_2_r2)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state and status decode.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (start)                  state_d = RUN;
            else if (accept && last_px) state_d = DONE;
         end
         DONE: begin
            done    = 1'b1;
            state_d = start ? RUN : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Raster position of the next pixel to be accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else if (start) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         if (col_q == COL_LAST) begin
            col_q <= '0;
            row_q <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   // Column shift registers: keep the two previous columns of the 3-row stripe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh_1_a <= '0;
         sh_1_b <= '0;
         sh_2_a <= '0;
         sh_2_b <= '0;
      end else if (accept) begin
         sh_1_a <= sh_1_b;
         sh_1_b <= new_1;
         sh_2_a <= sh_2_b;
         sh_2_b <= new_2;
      end
   end

   // Registered window output; ifmap holds its value between windows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_valid <= 1'b0;
         win_last  <= 1'b0;
         ifmap_1   <= '0;
         ifmap_2   <= '0;
      end else begin
         win_valid <= accept && win_ok;
         win_last  <= accept && win_ok && last_px;
         if (accept && win_ok) begin
            ifmap_1 <= pack_win(sh_1_a, sh_1_b, new_1);
            ifmap_2 <= pack_win(sh_2_a, sh_2_b, new_2);
         end
      end
   end

endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming 3x3 window generator that sits directly upstream of the two-channel convolution kernel. It accepts one FP16 pixel pair per accepted beat (channel 1 and channel 2) in raster order. It buffers the two previous image rows per channel and emits, for every valid output position, a registered pair of 3x3 windows on `ifmap_1` and `ifmap_2`, qualified by `win_valid`. Convolution is "valid" mode (no padding), so an IMG_H x IMG_W frame yields (IMG_H-2) x (IMG_W-2) windows.

## Interface
- `IMG_W`, default 28: frame width in pixels; minimum 3.
- `IMG_H`, default 28: frame height in pixels; minimum 3.
- `clk`  in  1  single clock, all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a new frame and clears the position counters.
- `in_valid`  in  1  pixel beat valid; no backpressure, every beat in RUN is accepted.
- `in_px_1`  in  16  FP16 pixel, channel 1.
- `in_px_2`  in  16  FP16 pixel, channel 2.
- `win_valid`  out  1  `ifmap_1`/`ifmap_2` hold a new window this cycle.
- `ifmap_1`  out  [8:0][15:0]  channel-1 window.
- `ifmap_2`  out  [8:0][15:0]  channel-2 window.
- `win_last`  out  1  with `win_valid`: this is the frame's final window.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the frame's last pixel is accepted.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: `in_valid` is ignored. `start` moves the FSM to RUN and zeroes `col`/`row`.
  - RUN: each `in_valid` beat writes the pixel into the window and line buffers, then advances `col`. At `col==IMG_W-1`, `col` wraps to 0 and `row` increments. The beat at (IMG_H-1, IMG_W-1) moves the FSM to DONE.
  - DONE: `done`=1 for exactly one cycle, then the FSM returns to IDLE.
- `start` in RUN or DONE restarts the frame: counters are zeroed and the FSM enters RUN.
- An `in_valid` beat in the same cycle as `start` is discarded, in every state.
- Window layout: index = 3*r + c.
  - r=0 is the oldest row (row-2); c=0 is the oldest column (col-2).
  - Index 8 is therefore the pixel just accepted.
  - This order matches the weight indexing of the kernel.
- A window is emitted for a beat at (row, col) when row>=2 and col>=2. It covers rows row-2..row and cols col-2..col.
- `win_last` is asserted on the window generated by the (IMG_H-1, IMG_W-1) beat.
- Line buffers: two rows of IMG_W entries per channel, addressed by `col`. Their contents are not reset; the row>=2/col>=2 gating makes stale data invisible.
- Arithmetic: pixels are passed through bit-exact; no FP operation is performed. Counters are `$clog2(IMG_W)` and `$clog2(IMG_H)` bits wide.
- Gaps in `in_valid` freeze all state. Windows stay contiguous in pixel order regardless of gap pattern.

## Timing
- Latency: window for a beat accepted in cycle N appears with `win_valid`=1 in cycle N+1.
- `ifmap_*` hold their last value while `win_valid`=0.
- `done` is asserted in cycle N+1 after the last beat (cycle N), coincident with the final `win_valid`/`win_last`.
- `busy` rises the cycle after `start` and falls the cycle `done` is asserted.
- Reset values: `win_valid`=0, `win_last`=0, `ifmap_1`=0, `ifmap_2`=0, `busy`=0, `done`=0, FSM=IDLE, counters=0.
- Reset mid-frame discards the frame: no further windows are produced until the next `start`.

## Structure
- Shared package `conv_pkg`:
  - `fp16_t` (logic [15:0]).
  - `win3x3_t` (fp16_t [8:0]).
  - `win_state_e` {IDLE, RUN, DONE}.
  - Constant `KSIZE=3`.
- Sub-module `conv_line_buf`: parameter DEPTH; 16-bit two-row delay line with write/read at the same address. Instantiated once per channel.
- Top level holds the FSM, the counters, and the 3x3 shift registers per channel.

## Test plan
- **Basic 4x4 frame.** Set IMG_W=IMG_H=4. Drive `in_px_1`=row*4+col and `in_px_2`=`in_px_1`|16'h8000, with `in_valid` high continuously. Expect exactly 4 windows. The first follows pixel 10 by one cycle, with `ifmap_1`[8:0] = {10,9,8,6,5,4,2,1,0} and `ifmap_2` the same values OR'd with 16'h8000. The last window is {15,14,13,11,10,9,7,6,5} with `win_last`=1 and `done`=1.
- **Random gaps.** Same frame with random `in_valid` gaps (about 50%). Expect identical window contents and order, each window exactly one cycle after its triggering beat.
- **Beats outside RUN.** `in_valid` pulses in IDLE, and on the `start` cycle, carrying value 16'hDEAD. Expect no window to contain 16'hDEAD.
- **Restart mid-frame.** `start` pulsed after 6 beats, then a full frame is driven. Expect 4 windows, all built only from post-restart pixels.
- **Reset mid-frame.** `rst` asserted after 11 beats. Expect all outputs 0 asynchronously, then no `win_valid` until a new `start`.
- **Default size.** IMG_W=IMG_H=28, back-to-back frames. Expect 676 windows per frame and one `done` pulse per frame.
